// File: rtl/snn_output_fifo_pkg.sv
// Shared constants for the SNN prediction FIFO: Wishbone register map and
// STATUS/CTRL field positions.
package snn_output_fifo_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned THR_W   = 8;
  localparam int unsigned GROUP_W = 16;

  // Word offsets on the 2-bit Wishbone address
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_GROUP  = 2'd3;

  // STATUS fields (count occupies [AW:0])
  localparam int unsigned ST_EMPTY    = 16;
  localparam int unsigned ST_FULL     = 17;
  localparam int unsigned ST_OVF      = 18;
  localparam int unsigned ST_DROP_LSB = 24;

  // CTRL fields
  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned CTRL_THR_LSB = 8;

endpackage

// File: rtl/snn_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a combinational
// head-of-queue read port.
// Ports: clk, rst (sync, active-high), clr (flush), push/din, pop/dout,
//        count (0..DEPTH), full, empty.
module snn_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   count_next;

  // A push on a full FIFO is accepted only when the head leaves in the same cycle
  assign do_push    = push & (~full | pop);
  assign do_pop     = pop & ~empty;
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout       = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/snn_output_fifo.sv
// SNN prediction capture: keeps the first output word of every inference
// group, buffers it, and exposes it to the CPU over a Wishbone classic slave.
// Ports: wb_clk/wb_rst (sync, active-high); snn_wr_en/snn_din word input;
//        wb_adr/wb_dat_i/wb_we/wb_cyc/wb_stb -> wb_dat_o/wb_ack (1-cycle);
//        irq level interrupt when enabled and count >= threshold.
module snn_output_fifo
  import snn_output_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned GROUP_RST = 1
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              snn_wr_en,
  input  logic [DATA_W-1:0] snn_din,
  input  logic [1:0]        wb_adr,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_we,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack,
  output logic              irq
);

  logic [GROUP_W-1:0] group_len;
  logic [GROUP_W-1:0] phase;
  logic               overflow;
  logic [DROP_W-1:0]  drop_cnt;
  logic               irq_en;
  logic [THR_W-1:0]   irq_thr;

  logic [DATA_W-1:0]  fifo_dout;
  logic [AW:0]        fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               acc_c;
  logic               wr_c;
  logic               rd_c;
  logic               flush_c;
  logic               group_wr_c;
  logic               ctrl_wr_c;
  logic               clear_c;
  logic               pop_c;
  logic               kept_c;
  logic               push_c;
  logic               drop_c;
  logic [GROUP_W-1:0] group_eff_c;
  logic [GROUP_W:0]   phase_inc_c;
  logic [AW:0]        count_next_c;
  logic               irq_en_next_c;
  logic [THR_W-1:0]   irq_thr_next_c;
  logic [DATA_W-1:0]  rd_data_c;
  logic               unused_ok;

  // Bus decode: a new access is taken only while no ack is outstanding
  assign acc_c      = wb_cyc & wb_stb & ~wb_ack;
  assign wr_c       = acc_c & wb_we;
  assign rd_c       = acc_c & ~wb_we;
  assign ctrl_wr_c  = wr_c & (wb_adr == ADR_CTRL);
  assign flush_c    = ctrl_wr_c & wb_dat_i[CTRL_FLUSH];
  assign group_wr_c = wr_c & (wb_adr == ADR_GROUP);
  assign clear_c    = wr_c & (wb_adr == ADR_STATUS) & wb_dat_i[ST_OVF];
  assign pop_c      = rd_c & (wb_adr == ADR_DATA) & ~fifo_empty;

  // Decimation: only phase 0 words survive; a zero length behaves as one
  assign group_eff_c = (group_len == '0) ? GROUP_W'(1) : group_len;
  assign phase_inc_c = {1'b0, phase} + (GROUP_W+1)'(1);
  assign kept_c      = snn_wr_en & (phase == '0) & ~flush_c;
  assign push_c      = kept_c & (~fifo_full | pop_c);
  assign drop_c      = kept_c & fifo_full & ~pop_c;

  // Occupancy and CTRL as they will be after this edge, so irq tracks count with no lag
  assign count_next_c   = flush_c ? '0
                        : fifo_count + (AW+1)'(push_c) - (AW+1)'(pop_c);
  assign irq_en_next_c  = ctrl_wr_c ? wb_dat_i[CTRL_IRQ_EN] : irq_en;
  assign irq_thr_next_c = ctrl_wr_c ? wb_dat_i[CTRL_THR_LSB +: THR_W] : irq_thr;

  assign unused_ok = ^{wb_dat_i[31:19], wb_dat_i[17:16]};

  snn_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .clr   (flush_c),
    .push  (push_c),
    .din   (snn_din),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read mux
  always_comb begin
    rd_data_c = '0;
    case (wb_adr)
      ADR_DATA:   rd_data_c = fifo_empty ? '0 : fifo_dout;
      ADR_STATUS: begin
        rd_data_c[AW:0]                       = fifo_count;
        rd_data_c[ST_EMPTY]                   = fifo_empty;
        rd_data_c[ST_FULL]                    = fifo_full;
        rd_data_c[ST_OVF]                     = overflow;
        rd_data_c[ST_DROP_LSB +: DROP_W]      = drop_cnt;
      end
      ADR_CTRL: begin
        rd_data_c[CTRL_IRQ_EN]                = irq_en;
        rd_data_c[CTRL_THR_LSB +: THR_W]      = irq_thr;
      end
      ADR_GROUP:  rd_data_c[GROUP_W-1:0]      = group_len;
      default:    rd_data_c = '0;
    endcase
  end

  // Bus response
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack <= acc_c;
      if (acc_c) wb_dat_o <= rd_data_c;
    end
  end

  // Control registers, decimation phase and overflow tracking
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      group_len <= GROUP_W'(GROUP_RST);
      phase     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      irq_en    <= 1'b0;
      irq_thr   <= THR_W'(1);
      irq       <= 1'b0;
    end else begin
      irq_en  <= irq_en_next_c;
      irq_thr <= irq_thr_next_c;
      irq     <= irq_en_next_c & (GROUP_W'(count_next_c) >= GROUP_W'(irq_thr_next_c));

      if (group_wr_c) group_len <= wb_dat_i[GROUP_W-1:0];

      if (flush_c || group_wr_c) begin
        phase <= '0;
      end else if (snn_wr_en) begin
        phase <= (phase_inc_c >= {1'b0, group_eff_c}) ? '0 : phase_inc_c[GROUP_W-1:0];
      end

      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
      if (flush_c || clear_c) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_snn_output_fifo.sv
// Scoreboard bench for snn_output_fifo: a queue-based reference model
// predicts every read; a monitor compares each read ack against it.
module tb_snn_output_fifo;

  localparam int DEPTH     = 16;
  localparam int GROUP_RST = 1;

  logic        wb_clk;
  logic        wb_rst;
  logic        snn_wr_en;
  logic [31:0] snn_din;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat_i;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        irq;

  snn_output_fifo #(.DEPTH(16), .AW(4), .GROUP_RST(1)) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .snn_wr_en (snn_wr_en),
    .snn_din   (snn_din),
    .wb_adr    (wb_adr),
    .wb_dat_i  (wb_dat_i),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_dat_o  (wb_dat_o),
    .wb_ack    (wb_ack),
    .irq       (irq)
  );

  always #5 wb_clk = ~wb_clk;

  // Reference model state
  logic [31:0] mq[$];
  int          m_phase, m_glen, m_drop, m_thr;
  bit          m_ovf, m_irq_en;

  logic [31:0] exp_q[$];
  int          n_checks, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic void model_reset();
    mq.delete();
    m_phase = 0; m_glen = GROUP_RST; m_drop = 0; m_thr = 1;
    m_ovf = 0; m_irq_en = 0;
  endfunction

  function automatic void model_word(input logic [31:0] w);
    int geff;
    geff = (m_glen == 0) ? 1 : m_glen;
    if (m_phase == 0) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_phase = (m_phase + 1) % geff;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[4:0]   = 5'(mq.size());
    s[16]    = (mq.size() == 0);
    s[17]    = (mq.size() == DEPTH);
    s[18]    = m_ovf;
    s[31:24] = 8'(m_drop);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] adr);
    logic [31:0] r;
    r = '0;
    case (adr)
      2'd0: if (mq.size() > 0) r = mq.pop_front();
      2'd1: r = model_status();
      2'd2: begin r[1] = m_irq_en; r[15:8] = 8'(m_thr); end
      default: r[15:0] = 16'(m_glen);
    endcase
    return r;
  endfunction

  function automatic void model_write(input logic [1:0] adr, input logic [31:0] d);
    case (adr)
      2'd1: if (d[18]) begin m_ovf = 0; m_drop = 0; end
      2'd2: begin
        if (d[0]) begin mq.delete(); m_phase = 0; m_ovf = 0; m_drop = 0; end
        m_irq_en = d[1];
        m_thr    = int'(d[15:8]);
      end
      2'd3: begin m_glen = int'(d[15:0]); m_phase = 0; end
      default: ;
    endcase
  endfunction

  function automatic bit model_irq();
    return m_irq_en && (mq.size() >= m_thr);
  endfunction

  // Consecutive SNN words, one per cycle; entered and left at posedge+1
  task automatic send_words(input int n, input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      snn_din   = base + 32'(i) * step;
      snn_wr_en = 1'b1;
      @(posedge wb_clk);
      model_word(snn_din);
      #1;
    end
    snn_wr_en = 1'b0;
  endtask

  // One Wishbone access, optionally with an SNN word landing on the ack edge
  task automatic wb_xfer(input logic [1:0] adr, input bit we, input logic [31:0] d,
                         input bit with_word, input logic [31:0] w);
    bit got;
    bit discard;
    discard = we && (adr == 2'd2) && d[0];
    if (!we) exp_q.push_back(model_read(adr));
    else model_write(adr, d);
    wb_adr = adr; wb_we = we; wb_dat_i = d; wb_cyc = 1'b1; wb_stb = 1'b1;
    if (with_word) begin snn_din = w; snn_wr_en = 1'b1; end
    @(posedge wb_clk);
    #1;
    snn_wr_en = 1'b0;
    if (with_word && !discard) model_word(w);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge wb_clk);
      if (wb_ack) got = 1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL wb_ack timeout: got no ack expected ack within 8 cycles");
    end
    @(posedge wb_clk);
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] adr);
    wb_xfer(adr, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] d);
    wb_xfer(adr, 1'b1, d, 1'b0, 32'h0);
  endtask

  task automatic chk_irq();
    @(negedge wb_clk);
    chk("irq level", 32'(irq), 32'(model_irq()));
    @(posedge wb_clk);
    #1;
  endtask

  // Monitor: every read ack is scored against the oldest prediction
  initial begin
    forever begin
      @(negedge wb_clk);
      if (wb_ack === 1'b1 && wb_we === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected read ack: got data %08h expected no ack", wb_dat_o);
        end else begin
          chk($sformatf("read adr%0d", wb_adr), wb_dat_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_pass = 0;
    wb_clk = 0; wb_rst = 1; snn_wr_en = 0; snn_din = '0;
    wb_adr = '0; wb_dat_i = '0; wb_we = 0; wb_cyc = 0; wb_stb = 0;
    model_reset();
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst = 0;

    // Reset state
    @(negedge wb_clk);
    chk("reset wb_ack", 32'(wb_ack), 32'h0);
    chk("reset wb_dat_o", wb_dat_o, 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    @(posedge wb_clk);
    #1;
    rd(2'd1); rd(2'd2); rd(2'd3);

    // Decimation by four
    wr(2'd3, 32'd4);
    send_words(8, 32'h0001_000A, 32'h0001_0001);
    rd(2'd0); rd(2'd0); rd(2'd0); rd(2'd1);

    // Overflow with every word kept
    wr(2'd3, 32'd1);
    send_words(18, 32'h0000_0100, 32'h1);
    rd(2'd1);
    rd(2'd0);

    // Pop and push on the same edge while full
    send_words(1, 32'h0000_0200, 32'h0);
    wb_xfer(2'd0, 1'b0, 32'h0, 1'b1, 32'hABCD_0300);
    rd(2'd1);
    for (int i = 0; i < 16; i++) rd(2'd0);
    rd(2'd1);

    // Interrupt threshold
    wr(2'd2, 32'h0000_0302);
    rd(2'd2);
    for (int i = 0; i < 3; i++) begin
      send_words(1, 32'h0000_0400 + 32'(i), 32'h0);
      chk_irq();
    end
    rd(2'd0);
    chk_irq();

    // Flush with overflow pending and a word arriving in the flush cycle
    wr(2'd2, 32'h0);
    send_words(16, 32'h0000_0500, 32'h1);
    for (int i = 0; i < 11; i++) rd(2'd0);
    rd(2'd1);
    wb_xfer(2'd2, 1'b1, 32'h1, 1'b1, 32'h0000_0600);
    rd(2'd1);
    rd(2'd2);

    // Drop counter saturation and write-1-to-clear
    send_words(280, 32'h0000_1000, 32'h1);
    rd(2'd1);
    wr(2'd1, 32'h0004_0000);
    rd(2'd1);
    for (int i = 0; i < 16; i++) rd(2'd0);

    // Randomised traffic
    for (int k = 0; k < 150; k++) begin
      int op;
      op = int'($urandom_range(0, 11));
      if (op <= 4) send_words(int'($urandom_range(1, 6)), $urandom, 32'h0001_0003);
      else if (op <= 7) rd(2'd0);
      else if (op == 8) rd(2'd1);
      else if (op == 9) wr(2'd3, 32'($urandom_range(0, 4)));
      else if (op == 10) wb_xfer(2'd0, 1'b0, 32'h0, 1'b1, $urandom);
      else wr(2'd1, 32'($urandom_range(0, 1)) << 18);
    end
    rd(2'd1);

    // Reset during a pending DATA read
    wr(2'd3, 32'd5);
    send_words(1, 32'h0000_7777, 32'h0);
    wb_adr = 2'd0; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1; wb_rst = 1'b1;
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    model_reset();
    @(negedge wb_clk);
    chk("ack after reset", 32'(wb_ack), 32'h0);
    @(posedge wb_clk);
    #1;
    rd(2'd1);
    rd(2'd3);

    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snn_output_fifo.md
Name: snn_output_fifo

Overview:
Downstream of the SNN output layer: captures output_buffer_wr_en/output_buffer_din words (two signed 16-bit class scores per word) and keeps only the first word of each inference group, which carries the prediction. Buffers kept words in a synchronous FIFO and exposes them to the SERV CPU through a Wishbone classic slave. Status flags, overflow tracking and a level interrupt let firmware drain predictions and print them over UART.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
AW, 4, log2(DEPTH)
GROUP_RST, 1, reset value of GROUP_LEN register (words per inference; NEURON_4/2 in system use)

Ports:
wb_clk  in  1  system clock; all logic on rising edge
wb_rst  in  1  synchronous, active-high reset
snn_wr_en  in  1  SNN output word valid (one word per cycle max)
snn_din  in  32  [15:0]=p1, [31:16]=p2, signed
wb_adr  in  2  word address: 0 DATA, 1 STATUS, 2 CTRL, 3 GROUP_LEN
wb_dat_i  in  32  write data
wb_we  in  1  write enable
wb_cyc  in  1  bus cycle
wb_stb  in  1  strobe
wb_dat_o  out  32  read data, registered
wb_ack  out  1  single-cycle acknowledge
irq  out  1  level interrupt: irq_en & (count >= irq_thr)

Behaviour:
- Reset: FIFO empty, count=0, phase=0, overflow=0, drop_cnt=0, GROUP_LEN=GROUP_RST, irq_en=0, irq_thr=1, wb_ack=0, wb_dat_o=0, irq=0.
- Decimation: phase counts every snn_wr_en word 0..GROUP_LEN-1, then wraps to 0. Word is kept only when phase==0. GROUP_LEN==0 treated as 1 (every word kept).
- Kept word with FIFO not full: pushed, visible to reads from the next cycle. Kept word with FIFO full and no pop that cycle: dropped, overflow<=1 (sticky), drop_cnt (8-bit) increments, saturating at 255. Discarded words (phase!=0) never count as drops.
- Wishbone: wb_ack<=1 for exactly one cycle when wb_cyc&wb_stb&!wb_ack. wb_dat_o is registered in that same cycle, so it is valid while ack is high. Latency is 1 cycle; back-to-back accesses yield ack every other cycle.
- DATA read (adr 0): returns head word and pops it on the ack cycle. When empty, returns 0 and does not pop. DATA write: ignored, still acked.
- STATUS read (adr 1): [AW:0]=count, [16]=empty, [17]=full, [18]=overflow, [31:24]=drop_cnt. Write with bit18=1 clears overflow and drop_cnt (write-1-to-clear).
- CTRL (adr 2): [0]=flush, self-clearing, reads 0; [1]=irq_en; [15:8]=irq_thr. Flush empties the FIFO and zeroes phase, overflow and drop_cnt in one cycle. A snn_wr_en word arriving in the flush cycle is discarded.
- GROUP_LEN (adr 3): [15:0], read/write. Writing it also zeroes phase.
- Simultaneous push and pop: allowed in any state, including full. Pop of the head and push of the new word happen in the same cycle; count is unchanged and no drop occurs when full.
- Pointers are AW-bit and wrap naturally. count is AW+1 bits, so DEPTH itself is representable.
- Reset mid-transfer: wb_rst overrides everything; any pending ack is cancelled the next cycle and stored data is lost.

Decomposition:
- Package snn_output_fifo_pkg:
  - register offsets (ADR_DATA, ADR_STATUS, ADR_CTRL, ADR_GROUP)
  - STATUS/CTRL bit positions
  - DROP_W=8
- Sub-module snn_sync_fifo (DEPTH, width 32): push, pop, dout, count, full, empty, with same-cycle push/pop on full. It holds the storage array and pointers. The top level holds decimation, registers, Wishbone and irq.

Test Plan:
- GROUP_LEN=4; drive 8 consecutive words 0x0001_000A..0x0008_0011 → FIFO holds 2 entries: 0x0001_000A then 0x0005_000E. Two DATA reads return these in order; a third read returns 0 with STATUS.empty=1.
- GROUP_LEN=1, DEPTH=16; push 18 words without reading → STATUS: count=16, full=1, overflow=1, drop_cnt=2. First DATA read returns word 0.
- FIFO full; a DATA read whose ack cycle coincides with a kept snn_wr_en → count stays 16, drop_cnt unchanged, and the new word appears last.
- irq_en=1, irq_thr=3; push 3 kept words → irq rises the cycle after the 3rd push. One DATA read → irq falls the cycle after ack.
- 5 words buffered with overflow=1; write CTRL flush=1 → next cycle count=0, empty=1, overflow=0, and CTRL reads back flush=0.
- Assert wb_rst for 1 cycle while wb_stb is held on a DATA read of a non-empty FIFO → wb_ack=0 in the following cycle, count=0, GROUP_LEN=GROUP_RST.
